// File: rtl/sr_pkg.sv
// Shared definitions for S/R flip-flop bank drivers.
// Contents: FSM states, default sizes, and the per-bit excitation function.
package sr_pkg;

  localparam int unsigned SrWidthDefault  = 8;
  localparam int unsigned SrSettleDefault = 2;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck
  } sr_state_e;

  // Returns {s, r} for one bit: 0->1 sets, 1->0 resets, otherwise hold (never both).
  function automatic logic [1:0] sr_excite(input logic cur, input logic tgt);
    return {tgt & ~cur, ~tgt & cur};
  endfunction

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Request handshake into an S/R bank command generator.
interface sr_cmd_gen_if #(
  parameter int unsigned WIDTH = 8
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] req_mask;

  modport master (output req_valid, output req_data, output req_mask, input req_ready);
  modport slave  (input req_valid, input req_data, input req_mask, output req_ready);

endinterface

// File: rtl/sr_settle_cnt.sv
// Loadable down-counter with zero flag, used to time bank settle periods.
module sr_settle_cnt #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_cmd_gen.sv
// Write-side command generator for a bank of S/R flip-flops.
// Define SR_CMD_GEN_READBACK_EN to verify and resync the shadow from the bank Q outputs.
module sr_cmd_gen
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH         = SrWidthDefault,
  parameter int unsigned SETTLE_CYCLES = SrSettleDefault
) (
  input  logic             clk,
  input  logic             rst,
  sr_cmd_gen_if.slave      req,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] fb_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] shadow_q
);

  localparam int unsigned CntW = (SETTLE_CYCLES == 0) ? 1 : $clog2(SETTLE_CYCLES + 1);
  // Loaded at DRIVE exit so SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [CntW-1:0] CntLoad = CntW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  sr_state_e        state_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] target_d;
  logic [WIDTH-1:0] set_m;
  logic [WIDTH-1:0] clr_m;
  logic [WIDTH-1:0] shadow_next;
  logic             accept;
  logic             cnt_zero;

  assign req.req_ready = (state_q == StIdle) && !rst;
  assign busy          = (state_q != StIdle);
  assign accept        = req.req_valid && req.req_ready;
  assign target_d      = (shadow_q & ~req.req_mask) | (req.req_data & req.req_mask);

  always_comb begin
    set_m = '0;
    clr_m = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      {set_m[i], clr_m[i]} = sr_excite(shadow_q[i], target_d[i]);
    end
  end

`ifdef SR_CMD_GEN_READBACK_EN
  assign err         = (state_q == StCheck) && (fb_q != target_q);
  assign shadow_next = fb_q;
`else
  logic unused_fb;
  assign unused_fb   = ^fb_q;
  assign err         = 1'b0;
  assign shadow_next = target_q;
`endif

  sr_settle_cnt #(
    .CntW (CntW)
  ) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == StDrive),
    .load_val (CntLoad),
    .dec      (state_q == StSettle),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      target_q <= '0;
      shadow_q <= '0;
      s_out    <= '0;
      r_out    <= '0;
      done     <= 1'b0;
    end else begin
      s_out <= '0;
      r_out <= '0;
      done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            target_q <= target_d;
            if ((set_m | clr_m) == '0) begin
              state_q <= StCheck;
              done    <= 1'b1;
            end else begin
              state_q <= StDrive;
              s_out   <= set_m;
              r_out   <= clr_m;
            end
          end
        end
        StDrive: begin
          if (SETTLE_CYCLES == 0) begin
            state_q <= StCheck;
            done    <= 1'b1;
          end else begin
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_zero) begin
            state_q <= StCheck;
            done    <= 1'b1;
          end
        end
        StCheck: begin
          shadow_q <= shadow_next;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
